// File: rtl/session_pkg.sv
// Shared types and constants for the login session controller.
package session_pkg;

  localparam int SEC_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    END    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_USER  = 2'b01,
    CAUSE_IDLE  = 2'b10,
    CAUSE_LIMIT = 2'b11
  } cause_t;

  function automatic logic [SEC_W-1:0] sat_dec(input logic [SEC_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running 1-second tick divider; counts only while run is high.
module sec_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Decoded from the registered count, so the first tick lands TICK_CYCLES
  // cycles after a clear.
  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/login_session_ctrl.sv
// Game session controller behind the ID/password access controller.
// Optional end-of-session warning blinker is built when SESSION_WARN_EN is defined.
module login_session_ctrl
  import session_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int IDLE_SEC    = 15,
  parameter int SESSION_SEC = 60,
  parameter int WARN_SEC    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_led,
  input  logic             pwd_led,
  input  logic [1:0]       id,
  input  logic             psh1_out,
  input  logic             psh2_out,
  input  logic             confirm_psh3_out,
  input  logic             logout_push,
  output logic             game_en,
  output logic [1:0]       player,
  output logic [SEC_W-1:0] time_left,
  output logic             logout_pulse,
  output logic [1:0]       cause,
  output logic             warn_led
);

  localparam logic [SEC_W-1:0] SESSION_INIT = SEC_W'(SESSION_SEC);
  localparam logic [SEC_W-1:0] IDLE_INIT    = SEC_W'(IDLE_SEC);

  state_t           state;
  logic [SEC_W-1:0] idle_cnt;
  logic             login_ok;
  logic             login_q;
  logic             login_rise;
  logic             activity;
  logic             start;
  logic             tick;
  logic             exit_now;
  cause_t           exit_cause;

  assign login_ok   = id_led & pwd_led;
  assign login_rise = login_ok & ~login_q;
  assign activity   = psh1_out | psh2_out | confirm_psh3_out;
  assign start      = (state == IDLE) && login_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      login_q <= 1'b0;
    end else begin
      login_q <= login_ok;
    end
  end

  sec_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (state == ACTIVE),
    .clear(start),
    .tick (tick)
  );

  // Exits are judged on registered counters, so an expiry shows up on
  // logout_pulse one cycle after the counter reaches zero.
  always_comb begin
    exit_now   = 1'b0;
    exit_cause = CAUSE_NONE;
    if (state == ACTIVE) begin
      if (logout_push) begin
        exit_now   = 1'b1;
        exit_cause = CAUSE_USER;
      end else if (time_left == '0) begin
        exit_now   = 1'b1;
        exit_cause = CAUSE_LIMIT;
      end else if (idle_cnt == '0) begin
        exit_now   = 1'b1;
        exit_cause = CAUSE_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      game_en      <= 1'b0;
      player       <= '0;
      time_left    <= '0;
      idle_cnt     <= '0;
      logout_pulse <= 1'b0;
      cause        <= CAUSE_NONE;
    end else begin
      logout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            player    <= id;
            time_left <= SESSION_INIT;
            idle_cnt  <= IDLE_INIT;
            cause     <= CAUSE_NONE;
            game_en   <= 1'b1;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (exit_now) begin
            logout_pulse <= 1'b1;
            game_en      <= 1'b0;
            cause        <= exit_cause;
            state        <= END;
          end else begin
            if (tick) begin
              time_left <= sat_dec(time_left);
            end
            // Activity beats a coincident tick.
            if (activity) begin
              idle_cnt <= IDLE_INIT;
            end else if (tick) begin
              idle_cnt <= sat_dec(idle_cnt);
            end
          end
        end
        END: begin
          // Wait for the accept level to drop so a held login cannot re-enter.
          if (!login_ok) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SESSION_WARN_EN
  logic             warn_q;
  logic [SEC_W-1:0] time_next;

  assign time_next = sat_dec(time_left);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warn_q <= 1'b0;
    end else if (state != ACTIVE || exit_now) begin
      warn_q <= 1'b0;
    end else if (tick) begin
      if (int'(time_next) <= WARN_SEC) begin
        // Entering the warning window always starts with the LED lit.
        warn_q <= (int'(time_left) > WARN_SEC) ? 1'b1 : ~warn_q;
      end else begin
        warn_q <= 1'b0;
      end
    end
  end

  assign warn_led = warn_q;
`else
  logic unused_warn_cfg;
  assign unused_warn_cfg = (WARN_SEC > 0);
  assign warn_led        = 1'b0;
`endif

endmodule

// File: tb/tb_login_session_ctrl.sv
// Directed bench for login_session_ctrl: vector table plus scoreboard of expected session ends.
module tb_login_session_ctrl;

  localparam int TC = 4;
  localparam int IS = 3;
  localparam int SS = 5;
  localparam int WS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_led = 1'b0;
  logic       pwd_led = 1'b0;
  logic [1:0] id = 2'b00;
  logic       psh1_out = 1'b0;
  logic       psh2_out = 1'b0;
  logic       confirm_psh3_out = 1'b0;
  logic       logout_push = 1'b0;
  logic       game_en;
  logic [1:0] player;
  logic [5:0] time_left;
  logic       logout_pulse;
  logic [1:0] cause;
  logic       warn_led;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] id;
    int         logout_at;
    int         act_period;
    int         act_last;
    bit         hold;
    logic [1:0] exp_cause;
    int         exp_cyc;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [1:0] cause;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];

  always #5 clk = ~clk;

  login_session_ctrl #(
    .TICK_CYCLES(TC),
    .IDLE_SEC   (IS),
    .SESSION_SEC(SS),
    .WARN_SEC   (WS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_led          (id_led),
    .pwd_led         (pwd_led),
    .id              (id),
    .psh1_out        (psh1_out),
    .psh2_out        (psh2_out),
    .confirm_psh3_out(confirm_psh3_out),
    .logout_push     (logout_push),
    .game_en         (game_en),
    .player          (player),
    .time_left       (time_left),
    .logout_pulse    (logout_pulse),
    .cause           (cause),
    .warn_led        (warn_led)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_tl(input int n);
    int v;
    v = SS - n / TC;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int exp_warn(input int n);
    int k;
    int tl;
    k  = n / TC;
    tl = SS - k;
`ifdef SESSION_WARN_EN
    if (tl <= WS && k > 0)
      return (((k - (SS - WS)) % 2) == 0) ? 1 : 0;
    return 0;
`else
    return (tl < 0) ? 1 : 0;
`endif
  endfunction

  task automatic run_vec(input vec_t v);
    int   n;
    bit   seen;
    exp_t e;
    e.cyc   = v.exp_cyc;
    e.cause = v.exp_cause;
    sb.push_back(e);
    id      = v.id;
    id_led  = 1'b1;
    pwd_led = 1'b1;
    step();
    check("start_game_en", game_en, 1);
    check("start_player", player, v.id);
    check("start_cause_cleared", cause, 0);
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      if (logout_pulse) begin
        seen = 1;
        e = sb.pop_front();
        check("pulse_cycle", n, e.cyc);
        check("end_cause", cause, e.cause);
        check("end_game_en", game_en, 0);
      end else begin
        check("time_left", time_left, exp_tl(n));
        check("active_game_en", game_en, 1);
        check("warn_led", warn_led, exp_warn(n));
        logout_push = (n == v.logout_at);
        psh1_out = (v.act_period > 0) && (n > 0) && (n % v.act_period == 0) && (n <= v.act_last);
        if (!v.hold && n == 2) id_led = 1'b0;
        step();
        n++;
      end
    end
    logout_push = 1'b0;
    psh1_out    = 1'b0;
    if (!seen) begin
      check("logout_timeout", 0, 1);
      void'(sb.pop_front());
    end else begin
      step();
      check("pulse_width", logout_pulse, 0);
      check("cause_held", cause, v.exp_cause);
    end
  endtask

  task automatic drop_login();
    id_led  = 1'b0;
    pwd_led = 1'b0;
    step();
    step();
    check("idle_game_en", game_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b10, 6,  0, 0,  1'b1, 2'b01, 7};
    vecs[1] = '{2'b01, -1, 0, 0,  1'b0, 2'b10, 13};
    vecs[2] = '{2'b11, -1, 8, 99, 1'b1, 2'b11, 21};
    vecs[3] = '{2'b00, 20, 9, 9,  1'b1, 2'b01, 21};

    #12;
    check("rst_game_en", game_en, 0);
    check("rst_player", player, 0);
    check("rst_time_left", time_left, 0);
    check("rst_logout_pulse", logout_pulse, 0);
    check("rst_cause", cause, 0);
    check("rst_warn_led", warn_led, 0);
    rst = 1'b0;
    step();

    // User logout, then keep the accept level high: no new session may start.
    run_vec(vecs[0]);
    for (int i = 0; i < 5; i++) begin
      check("end_hold_game_en", game_en, 0);
      check("end_hold_pulse", logout_pulse, 0);
      check("end_hold_cause", cause, 2'b01);
      step();
    end
    drop_login();

    for (int i = 1; i < 4; i++) begin
      run_vec(vecs[i]);
      drop_login();
    end

    // Asynchronous reset mid-session.
    id      = 2'b01;
    id_led  = 1'b1;
    pwd_led = 1'b1;
    step();
    step();
    step();
    step();
    check("pre_rst_game_en", game_en, 1);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_game_en", game_en, 0);
    check("midrst_player", player, 0);
    check("midrst_time_left", time_left, 0);
    check("midrst_logout_pulse", logout_pulse, 0);
    check("midrst_cause", cause, 0);
    check("midrst_warn_led", warn_led, 0);
    step();
    id_led  = 1'b0;
    pwd_led = 1'b0;
    rst     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_pulse", logout_pulse, 0);
      check("post_rst_game_en", game_en, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
